// File: rtl/shift_arbiter_if.sv
// Bus bundle for shift_arbiter: two requesters with operands and grants,
// one result channel with valid/ready, and the per-requester grant counters.
interface shift_arbiter_if;
  logic        req0;
  logic        req1;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [3:0]  amt0;
  logic [3:0]  amt1;
  logic        mode0;
  logic        mode1;
  logic        gnt0;
  logic        gnt1;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_id;
  logic        res_ready;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  // Arbiter side.
  modport slave (
    input  req0, req1, data0, data1, amt0, amt1, mode0, mode1, res_ready,
    output gnt0, gnt1, res_valid, res_data, res_id, cnt0, cnt1
  );

  // Requester / consumer side.
  modport master (
    output req0, req1, data0, data1, amt0, amt1, mode0, mode1, res_ready,
    input  gnt0, gnt1, res_valid, res_data, res_id, cnt0, cnt1
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 16-bit barrel shifter (SLL / SRA).
// Round-robin grant, one-entry result register with valid/ready handshake.
// Optional macro SHIFT_ARB_CNT_EN adds saturating 8-bit grant counters;
// without it cnt0/cnt1 are tied to zero.
module shift_arbiter #(
  parameter int FIRST_PRIO = 0
) (
  input logic             clk,
  input logic             rst_n,
  shift_arbiter_if.slave  bus
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]  state;
  logic        prio;        // 1: requester 1 wins the next contention
  logic        can_accept;
  logic        gnt0;
  logic        gnt1;
  logic        grant_any;
  logic [15:0] sh_data;
  logic [3:0]  sh_amt;
  logic        sh_mode;
  logic [15:0] sh_res;
  logic [15:0] res_data;
  logic        res_id;

  // Grant decision: only when the result slot can take a new value.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    can_accept = (state == EMPTY) || bus.res_ready;
    if (rst_n && can_accept) begin
      if (bus.req0 && (!bus.req1 || !prio)) begin
        gnt0 = 1'b1;
      end else if (bus.req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign grant_any = gnt0 || gnt1;

  // Shared shifter, fed by the requester being granted this cycle.
  always_comb begin
    sh_data = gnt1 ? bus.data1 : bus.data0;
    sh_amt  = gnt1 ? bus.amt1  : bus.amt0;
    sh_mode = gnt1 ? bus.mode1 : bus.mode0;
    if (sh_mode) begin
      sh_res = 16'($signed(sh_data) >>> sh_amt);
    end else begin
      sh_res = sh_data << sh_amt;
    end
  end

  // Result register, EMPTY/FULL state and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    if (!rst_n) begin
      state    <= EMPTY;
      // NOTE: the result datapath is reset too, so a discarded result never leaks after reset.
      res_data <= 16'h0000;
      res_id   <= 1'b0;
      prio     <= (FIRST_PRIO != 0);
    end else begin
      if (grant_any) begin
        state    <= FULL;
        res_data <= sh_res;
        res_id   <= gnt1;
        prio     <= gnt0;   // favour the requester that was not just served
      end else if (bus.res_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.res_valid = (state == FULL);
  assign bus.res_data  = res_data;
  assign bus.res_id    = res_id;

`ifdef SHIFT_ARB_CNT_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 8'h00;
      cnt1 <= 8'h00;
    end else begin
      if (gnt0 && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'h01;
      if (gnt1 && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'h01;
    end
  end

  assign bus.cnt0 = cnt0;
  assign bus.cnt1 = cnt1;
`else
  assign bus.cnt0 = 8'h00;
  assign bus.cnt1 = 8'h00;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: a cycle-by-cycle vector table plus
// hand-written reset and counter sequences.
module tb_shift_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_cnt0;
  int   exp_cnt1;

  shift_arbiter_if bus ();

  shift_arbiter #(.FIRST_PRIO(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req0;
    logic        req1;
    logic [15:0] d0;
    logic [3:0]  a0;
    logic        m0;
    logic [15:0] d1;
    logic [3:0]  a1;
    logic        m1;
    logic        rdy;
    logic        g0;     // expected gnt0 before the edge
    logic        g1;     // expected gnt1 before the edge
    logic        v;      // expected res_valid after the edge
    logic [15:0] rd;     // expected res_data after the edge (when v)
    logic        rid;    // expected res_id after the edge (when v)
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
    check({tag, " cnt0"}, {8'h00, bus.cnt0}, 16'(exp_cnt0));
    check({tag, " cnt1"}, {8'h00, bus.cnt1}, 16'(exp_cnt1));
  endtask

  // Apply one vector for one clock cycle and compare grants and result.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    bus.req0      = v.req0;
    bus.req1      = v.req1;
    bus.data0     = v.d0;
    bus.amt0      = v.a0;
    bus.mode0     = v.m0;
    bus.data1     = v.d1;
    bus.amt1      = v.a1;
    bus.mode1     = v.m1;
    bus.res_ready = v.rdy;
    #1;
    check({tag, " gnt0"}, {15'h0, bus.gnt0}, {15'h0, v.g0});
    check({tag, " gnt1"}, {15'h0, bus.gnt1}, {15'h0, v.g1});
`ifdef SHIFT_ARB_CNT_EN
    if (v.g0 && exp_cnt0 < 255) exp_cnt0++;
    if (v.g1 && exp_cnt1 < 255) exp_cnt1++;
`endif
    @(posedge clk);
    #1;
    check({tag, " res_valid"}, {15'h0, bus.res_valid}, {15'h0, v.v});
    if (v.v) begin
      check({tag, " res_data"}, bus.res_data, v.rd);
      check({tag, " res_id"}, {15'h0, bus.res_id}, {15'h0, v.rid});
    end
    check_cnt(tag);
  endtask

  initial begin
    vec_t vr;
    checks   = 0;
    errors   = 0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;

    //            r0 r1  d0        a0 m0  d1        a1 m1  rdy g0 g1 v  rd        rid
    tbl[0]  = '{1, 0, 16'h8001, 1,  1, 16'h0000, 0,  0, 1,  1, 0, 1, 16'hC000, 0};
    tbl[1]  = '{1, 0, 16'hFFFF, 15, 0, 16'h0000, 0,  0, 1,  1, 0, 1, 16'h8000, 0};
    tbl[2]  = '{1, 0, 16'hFFFF, 0,  0, 16'h0000, 0,  0, 1,  1, 0, 1, 16'hFFFF, 0};
    tbl[3]  = '{0, 1, 16'h0000, 0,  0, 16'h1234, 4,  0, 1,  0, 1, 1, 16'h2340, 1};
    tbl[4]  = '{0, 1, 16'h0000, 0,  0, 16'h8000, 15, 1, 1,  0, 1, 1, 16'hFFFF, 1};
    tbl[5]  = '{0, 1, 16'h0000, 0,  0, 16'h7FFF, 3,  1, 1,  0, 1, 1, 16'h0FFF, 1};
    tbl[6]  = '{0, 0, 16'h0000, 0,  0, 16'h0000, 0,  0, 1,  0, 0, 0, 16'h0000, 0};
    // Both requesting for six cycles: strict alternation.
    tbl[7]  = '{1, 1, 16'h0001, 1,  0, 16'h0010, 1,  1, 1,  1, 0, 1, 16'h0002, 0};
    tbl[8]  = '{1, 1, 16'h0001, 1,  0, 16'h0010, 1,  1, 1,  0, 1, 1, 16'h0008, 1};
    tbl[9]  = '{1, 1, 16'h0001, 1,  0, 16'h0010, 1,  1, 1,  1, 0, 1, 16'h0002, 0};
    tbl[10] = '{1, 1, 16'h0001, 1,  0, 16'h0010, 1,  1, 1,  0, 1, 1, 16'h0008, 1};
    tbl[11] = '{1, 1, 16'h0001, 1,  0, 16'h0010, 1,  1, 1,  1, 0, 1, 16'h0002, 0};
    tbl[12] = '{1, 1, 16'h0001, 1,  0, 16'h0010, 1,  1, 1,  0, 1, 1, 16'h0008, 1};
    // Stall: result held, req1 waits three cycles, then granted.
    tbl[13] = '{1, 0, 16'h00F0, 4,  0, 16'h0000, 0,  0, 1,  1, 0, 1, 16'h0F00, 0};
    tbl[14] = '{0, 1, 16'h0000, 0,  0, 16'hF000, 4,  1, 0,  0, 0, 1, 16'h0F00, 0};
    tbl[15] = '{0, 1, 16'h0000, 0,  0, 16'hF000, 4,  1, 0,  0, 0, 1, 16'h0F00, 0};
    tbl[16] = '{0, 1, 16'h0000, 0,  0, 16'hF000, 4,  1, 0,  0, 0, 1, 16'h0F00, 0};
    tbl[17] = '{0, 1, 16'h0000, 0,  0, 16'hF000, 4,  1, 1,  0, 1, 1, 16'hFF00, 1};
    tbl[18] = '{0, 0, 16'h0000, 0,  0, 16'h0000, 0,  0, 0,  0, 0, 1, 16'hFF00, 1};
    tbl[19] = '{0, 0, 16'h0000, 0,  0, 16'h0000, 0,  0, 1,  0, 0, 0, 16'h0000, 0};

    // Reset state.
    rst_n         = 1'b0;
    bus.req0      = 1'b1;
    bus.req1      = 1'b1;
    bus.data0     = 16'h0;
    bus.data1     = 16'h0;
    bus.amt0      = 4'h0;
    bus.amt1      = 4'h0;
    bus.mode0     = 1'b0;
    bus.mode1     = 1'b0;
    bus.res_ready = 1'b1;
    #1;
    check("rst gnt0", {15'h0, bus.gnt0}, 16'h0);
    check("rst gnt1", {15'h0, bus.gnt1}, 16'h0);
    check("rst res_valid", {15'h0, bus.res_valid}, 16'h0);
    check("rst res_data", bus.res_data, 16'h0000);
    check("rst res_id", {15'h0, bus.res_id}, 16'h0);
    check_cnt("rst");
    repeat (2) @(negedge clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while a result is held: cleared at once, nothing replayed.
    @(negedge clk);
    bus.req0      = 1'b1;
    bus.data0     = 16'h0003;
    bus.amt0      = 4'd1;
    bus.mode0     = 1'b0;
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;
`ifdef SHIFT_ARB_CNT_EN
    if (exp_cnt0 < 255) exp_cnt0++;
`endif
    check("hold res_valid", {15'h0, bus.res_valid}, 16'h1);
    check("hold res_data", bus.res_data, 16'h0006);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    check("midrst res_valid", {15'h0, bus.res_valid}, 16'h0);
    check("midrst res_data", bus.res_data, 16'h0000);
    check("midrst gnt0", {15'h0, bus.gnt0}, 16'h0);
    check_cnt("midrst");
    @(negedge clk);
    bus.req0      = 1'b0;
    bus.res_ready = 1'b0;
    rst_n         = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst res_valid", {15'h0, bus.res_valid}, 16'h0);

    // First contention after reset goes to requester 0 on the first edge.
    vr = '{1, 1, 16'h0005, 2, 0, 16'h0050, 2, 0, 1, 1, 0, 1, 16'h0014, 0};
    step(vr, "first-prio");
    vr = '{1, 1, 16'h0005, 2, 0, 16'h0050, 2, 0, 1, 0, 1, 1, 16'h0140, 1};
    step(vr, "rr-after-rst");

    // 300 grants to requester 0; counters saturate or stay at zero.
    vr = '{1, 0, 16'h0001, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 1, 16'h0001, 0};
    for (int i = 0; i < 300; i++) begin
      step(vr, "burst");
    end
`ifdef SHIFT_ARB_CNT_EN
    check("sat cnt0", {8'h00, bus.cnt0}, 16'h00FF);
`else
    check("sat cnt0", {8'h00, bus.cnt0}, 16'h0000);
`endif
    check("sat cnt1", {8'h00, bus.cnt1}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: FIRST_PRIO, default 0, requester index (0 or 1) favoured on the first contended cycle after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0, req1  input  1 each  request valid per requester; held with operands until granted.
REQ-005 data0, data1  input  16 each  operand to shift.
REQ-006 amt0, amt1  input  4 each  unsigned shift amount, 0-15.
REQ-007 mode0, mode1  input  1 each  0 = shift left logical, 1 = shift right arithmetic.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant; request consumed on a cycle where reqN && gntN.
REQ-009 res_valid  output  1  result register holds an unconsumed result.
REQ-010 res_data  output  16  shifted result.
REQ-011 res_id  output  1  index of the requester that owns res_data.
REQ-012 res_ready  input  1  consumer accepts result on a cycle where res_valid && res_ready.
REQ-013 cnt0, cnt1  output  8 each  grant counters (see Configuration).

Function
REQ-014 Block shares one 16-bit barrel shifter between two requesters; shifter is combinational on the selected request's data/amt/mode.
REQ-015 SLL: zero-fill from bit 0; SRA: bit 15 replicated into vacated MSBs; amt 0 passes data unchanged.
REQ-016 can_accept = !res_valid || res_ready; grant issued only when can_accept is 1.
REQ-017 gnt0/gnt1 combinational from req0/req1, can_accept and priority pointer; at most one grant high per cycle; grant never asserted without corresponding req.
REQ-018 Only one requester active -> that requester granted.
REQ-019 Both active -> requester not granted most recently wins (round-robin); pointer updates only on an actual grant.
REQ-020 Latency: request granted in cycle N -> res_valid=1 with res_data/res_id in cycle N+1.
REQ-021 Throughput 1 per cycle: result consumed and new grant in same cycle -> result register reloads, res_valid stays 1.
REQ-022 Result consumed, no grant same cycle -> res_valid falls to 0 next cycle.
REQ-023 res_valid && !res_ready -> res_data, res_id, res_valid held stable; no grants.
REQ-024 States: EMPTY (res_valid=0), FULL (res_valid=1); EMPTY->FULL on grant; FULL->EMPTY on consume without grant; FULL->FULL on consume with grant or stall.

Reset
REQ-025 rst_n low asynchronously clears res_valid, res_data=16'h0000, res_id=0, cnt0=cnt1=0, pointer so FIRST_PRIO wins next contention; gnt0/gnt1 forced 0 while rst_n low.
REQ-026 Reset mid-operation discards any held result; no result is replayed after release.
REQ-027 First grant possible on first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro SHIFT_ARB_CNT_EN defined: cntN increments by 1 on each grant to requester N, saturating at 8'hFF.
REQ-029 SHIFT_ARB_CNT_EN undefined: no counter registers, cnt0 and cnt1 driven constant 0; all other behaviour identical.

Verification
REQ-030 Reset, then req0=1, data0=16'h8001, amt0=1, mode0=1, res_ready=1 -> gnt0 cycle 1, next cycle res_valid=1, res_data=16'hC000, res_id=0.
REQ-031 SLL boundary: data=16'hFFFF, amt=15, mode=0 -> res_data=16'h8000; amt=0 -> res_data=16'hFFFF.
REQ-032 req0 and req1 held high 6 cycles, res_ready=1, FIRST_PRIO=0 -> grants alternate 0,1,0,1,0,1; res_id follows one cycle later.
REQ-033 res_ready=0 with result held, req1 high 3 cycles -> gnt1=0, res_data stable; res_ready=1 -> gnt1 same cycle, new result next cycle.
REQ-034 Assert rst_n low while res_valid=1 -> res_valid=0 immediately, counters 0, no stale result after release.
REQ-035 With SHIFT_ARB_CNT_EN, 300 grants to requester 0 -> cnt0=8'hFF, cnt1=0; without macro cnt0=cnt1=0 throughout.
